// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer
// Multi-channel programmable down-counting phase timer. Each channel can be
// started, restarted, held and stopped independently and runs either as a
// one-shot or with auto-reload. Per channel it produces a registered
// one-cycle expiry pulse, a busy flag and a sticky expiry flag. A
// combinational readback mux exposes one channel's count for the pedestrian
// countdown display.
//
// Handshake/control semantics: there is no valid/ready pairing here. Every
// control input (start, stop, hold, clr, mode) is a level sampled at each
// rising clk edge. Per channel the priority is stop > start > hold > count.
// The per-channel FSM state (IDLE/RUN) is visible directly on busy.
module traffic_phase_timer #(
  parameter int NBITS = 32,
  parameter int NCH   = 4,
  parameter int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*NBITS-1:0] cnt_ini,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       hold,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       clr,
  input  logic [SELW-1:0]      rd_sel,
  output logic [NCH-1:0]       timer,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       expired,
  output logic [NBITS-1:0]     cnt_out
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q [NCH];
  logic [NBITS-1:0] cnt_q   [NCH];
  logic [NCH-1:0]   expire;

  // A running, unheld channel with count 0 or 1 reaches the end of its
  // interval on this edge, unless stop or start overrides it.
  always_comb begin
    expire = '0;
    for (int c = 0; c < NCH; c++) begin
      expire[c] = (state_q[c] == ST_RUN) && !stop[c] && !start[c] && !hold[c] &&
                  (cnt_q[c] <= NBITS'(1));
    end
  end

  // Per-channel FSM, count register, expiry pulse and sticky expiry flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      timer   <= '0;
      expired <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        timer[c] <= expire[c];

        if (stop[c]) begin
          state_q[c] <= ST_IDLE;
          cnt_q[c]   <= '0;
        end else if (start[c]) begin
          // Restarting a running channel silently abandons the old interval.
          state_q[c] <= ST_RUN;
          cnt_q[c]   <= cnt_ini[c*NBITS +: NBITS];
        end else if (expire[c]) begin
          // mode and cnt_ini are taken at the moment of expiry.
          if (mode[c]) begin
            cnt_q[c] <= cnt_ini[c*NBITS +: NBITS];
          end else begin
            state_q[c] <= ST_IDLE;
            cnt_q[c]   <= '0;
          end
        end else if ((state_q[c] == ST_RUN) && !hold[c]) begin
          cnt_q[c] <= cnt_q[c] - NBITS'(1);
        end

        // A coincident expiry wins over a clear so no event is lost.
        if (expire[c]) begin
          expired[c] <= 1'b1;
        end else if (clr[c]) begin
          expired[c] <= 1'b0;
        end
      end
    end
  end

  // busy is the registered FSM state itself.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      busy[c] = (state_q[c] == ST_RUN);
    end
  end

  // Readback mux; an out-of-range select reads as zero.
  always_comb begin
    cnt_out = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(rd_sel) == c) begin
        cnt_out = cnt_q[c];
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer
// Directed bench for traffic_phase_timer. A behavioural model tracks, per
// channel, the interval length and how many counting cycles have elapsed;
// the shown count is length minus progress. A negedge compare process checks
// every output against the model each cycle, and directed literal checks pin
// the model to hand-computed values.
module tb_traffic_phase_timer;

  localparam int NBITS = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*NBITS-1:0] cnt_ini;
  logic [NCH-1:0]       start, stop, hold, mode, clr;
  logic [SELW-1:0]      rd_sel;
  logic [NCH-1:0]       timer, busy, expired;
  logic [NBITS-1:0]     cnt_out;

  always #5 clk = ~clk;

  traffic_phase_timer #(.NBITS(NBITS), .NCH(NCH), .SELW(SELW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_ini (cnt_ini),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .mode    (mode),
    .clr     (clr),
    .rd_sel  (rd_sel),
    .timer   (timer),
    .busy    (busy),
    .expired (expired),
    .cnt_out (cnt_out)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_len  [NCH];
  int unsigned m_prog [NCH];
  bit          m_run  [NCH];
  bit          m_tmr  [NCH];
  bit          m_exp  [NCH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_len[c] = 0; m_prog[c] = 0; m_run[c] = 0; m_tmr[c] = 0; m_exp[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_tmr[c] = 0;
        if (stop[c]) begin
          m_run[c] = 0; m_len[c] = 0; m_prog[c] = 0;
        end else if (start[c]) begin
          m_run[c] = 1; m_len[c] = cnt_ini[c*NBITS +: NBITS]; m_prog[c] = 0;
        end else if (m_run[c] && !hold[c]) begin
          m_prog[c]++;
          // an interval of 0 lasts one cycle, like an interval of 1
          if (m_prog[c] >= ((m_len[c] == 0) ? 1 : m_len[c])) begin
            m_tmr[c] = 1;
            m_exp[c] = 1;
            m_prog[c] = 0;
            if (mode[c]) m_len[c] = cnt_ini[c*NBITS +: NBITS];
            else begin m_run[c] = 0; m_len[c] = 0; end
          end
        end
        if (clr[c] && !m_tmr[c]) m_exp[c] = 0;
      end
    end
  end

  function automatic logic [NBITS-1:0] m_count(input int c);
    return m_run[c] ? NBITS'(m_len[c] - m_prog[c]) : '0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [NCH-1:0]   e_tmr, e_busy, e_exp;
    logic [NBITS-1:0] e_cnt;
    for (int c = 0; c < NCH; c++) begin
      e_tmr[c]  = m_tmr[c];
      e_busy[c] = m_run[c];
      e_exp[c]  = m_exp[c];
    end
    e_cnt = (int'(rd_sel) < NCH) ? m_count(int'(rd_sel)) : '0;
    check("cmp_timer",   64'(timer),   64'(e_tmr));
    check("cmp_busy",    64'(busy),    64'(e_busy));
    check("cmp_expired", 64'(expired), 64'(e_exp));
    check("cmp_cnt_out", 64'(cnt_out), 64'(e_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ini(input int c, input logic [NBITS-1:0] v);
    cnt_ini[c*NBITS +: NBITS] = v;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; cnt_ini = '0; start = '0; stop = '0; hold = '0;
    mode = '0; clr = '0; rd_sel = '0;
    tick(); tick();
    check("rst_timer",   64'(timer),   64'h0);
    check("rst_busy",    64'(busy),    64'h0);
    check("rst_expired", 64'(expired), 64'h0);
    check("rst_cnt_out", 64'(cnt_out), 64'h0);
    reset = 1'b0;
    tick();

    // Ch0 one-shot, interval 5.
    set_ini(0, 5); mode[0] = 1'b0; rd_sel = 0;
    start[0] = 1'b1; tick(); start[0] = 1'b0;          // edge 0
    check("t1_busy_e0", 64'(busy[0]), 64'h1);
    check("t1_cnt_e0",  64'(cnt_out), 64'd5);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_timer_pre", 64'(timer[0]), 64'h0);
      check("t1_busy_pre",  64'(busy[0]),  64'h1);
    end
    tick();                                            // edge 5
    check("t1_timer_e5", 64'(timer), 64'h1);
    check("t1_busy_e5",  64'(busy[0]), 64'h0);
    check("t1_exp_e5",   64'(expired[0]), 64'h1);
    tick();
    check("t1_timer_e6", 64'(timer[0]), 64'h0);
    check("t1_exp_e6",   64'(expired[0]), 64'h1);
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("t1_clr", 64'(expired[0]), 64'h0);

    // Ch1 auto-reload, interval 3, stop at edge 10.
    set_ini(1, 3); mode[1] = 1'b1; rd_sel = 1;
    start[1] = 1'b1; tick(); start[1] = 1'b0;          // edge 0
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("t2_timer", 64'(timer[1]), (k % 3 == 0) ? 64'h1 : 64'h0);
      check("t2_busy",  64'(busy[1]),  64'h1);
    end
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;            // edge 10
    check("t2_busy_stop", 64'(busy[1]), 64'h0);
    check("t2_cnt_stop",  64'(cnt_out), 64'h0);
    check("t2_exp_stop",  64'(expired[1]), 64'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_timer_after", 64'(timer[1]), 64'h0);
    end
    mode[1] = 1'b0;

    // Ch2 interval 4, hold over edges 2..4.
    set_ini(2, 4); rd_sel = 2;
    start[2] = 1'b1; tick(); start[2] = 1'b0;          // edge 0
    tick();                                            // edge 1
    check("t3_cnt_e1", 64'(cnt_out), 64'd3);
    hold[2] = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("t3_cnt_hold", 64'(cnt_out), 64'd3);
      check("t3_timer_hold", 64'(timer[2]), 64'h0);
    end
    hold[2] = 1'b0;
    tick(); tick();                                    // edges 5, 6
    check("t3_timer_e6", 64'(timer[2]), 64'h0);
    tick();                                            // edge 7
    check("t3_timer_e7", 64'(timer[2]), 64'h1);

    // Ch3 restart at edge 3, then a zero interval.
    set_ini(3, 6); mode[3] = 1'b0; rd_sel = 3;
    start[3] = 1'b1; tick(); start[3] = 1'b0;          // edge 0
    tick(); tick();                                    // edges 1, 2
    start[3] = 1'b1; tick(); start[3] = 1'b0;          // edge 3
    check("t4_cnt_restart", 64'(cnt_out), 64'd6);
    for (int k = 4; k <= 10; k++) begin
      tick();
      check("t4_timer", 64'(timer[3]), (k == 9) ? 64'h1 : 64'h0);
    end
    set_ini(3, 0);
    start[3] = 1'b1; tick(); start[3] = 1'b0;          // edge 0
    check("t4_zero_busy", 64'(busy[3]), 64'h1);
    tick();                                            // edge 1
    check("t4_zero_timer", 64'(timer[3]), 64'h1);
    check("t4_zero_busy1", 64'(busy[3]), 64'h0);

    // Reset mid-interval on all channels.
    for (int c = 0; c < NCH; c++) set_ini(c, 10);
    mode = '0; rd_sel = 0;
    start = '1; tick(); start = '0;                    // edge 0
    tick();                                            // edge 1
    check("t5_busy_pre", 64'(busy), 64'hF);
    @(posedge clk);                                    // edge 2
    #1 reset = 1'b1;
    #1;
    check("t5_rst_timer",   64'(timer),   64'h0);
    check("t5_rst_busy",    64'(busy),    64'h0);
    check("t5_rst_expired", 64'(expired), 64'h0);
    check("t5_rst_cnt",     64'(cnt_out), 64'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t5_post_timer", 64'(timer), 64'h0);
      check("t5_post_busy",  64'(busy),  64'h0);
    end

    // Clear coinciding with expiry on ch0: set wins.
    set_ini(0, 2); mode[0] = 1'b1;
    start[0] = 1'b1; tick(); start[0] = 1'b0;          // edge 0
    tick(); tick();                                    // edges 1, 2
    check("t6_exp_e2", 64'(expired[0]), 64'h1);
    tick();                                            // edge 3
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;              // edge 4 expires
    check("t6_timer_e4", 64'(timer[0]), 64'h1);
    check("t6_exp_set_wins", 64'(expired[0]), 64'h1);
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    check("t6_exp_cleared", 64'(expired[0]), 64'h0);
    mode[0] = 1'b0;

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Multi-channel programmable phase timer for the traffic signal controller: a parametrised successor to the single-channel free-running match timer. Each channel is an independent down-counter that can be started, held, stopped and run in one-shot or auto-reload mode. It raises a one-cycle expiry pulse and a sticky expiry flag per channel. It sits between the signal-phase state machine (which starts and stops phase intervals) and the light-output logic; the count readback port feeds the pedestrian countdown display.

## Interface

- NBITS, 32, counter width per channel
- NCH, 4, number of independent channels
- SELW, $clog2(NCH) (min 1), width of readback select
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-high; clears all state immediately
- cnt_ini  input  NCH*NBITS  per-channel interval in cycles; channel c at bits [c*NBITS +: NBITS]
- start  input  NCH  per-channel start/restart request, level-sampled each cycle
- stop  input  NCH  per-channel abort request
- hold  input  NCH  per-channel freeze; count is kept while high
- mode  input  NCH  per-channel mode: 0 = one-shot, 1 = auto-reload
- clr  input  NCH  per-channel clear of the sticky expired flag
- rd_sel  input  SELW  channel selected for readback
- timer  output  NCH  registered one-cycle expiry pulse per channel
- busy  output  NCH  registered; 1 while the channel is in RUN
- expired  output  NCH  registered sticky expiry flag per channel
- cnt_out  output  NBITS  combinational mux of the selected channel's count; 0 if rd_sel >= NCH

## Operation

- Each channel has two states, IDLE and RUN, plus an NBITS count register. Channels are fully independent.
- Per-channel priority each cycle: stop > start > hold > count.
- stop: go to IDLE, count <= 0. No timer pulse and no change to expired.
- start, from IDLE or RUN: go to RUN, count <= cnt_ini slice. A start in RUN restarts the interval; no pulse is issued for the aborted interval.
- RUN with hold=1: count and state unchanged; timer=0.
- RUN with hold=0:
  - If count <= 1, timer pulses for the next cycle and expired is set.
  - In that case, mode=1 reloads count <= cnt_ini (current slice value) and stays in RUN.
  - In that case, mode=0 goes to IDLE with count <= 0.
  - Otherwise count <= count - 1.
- cnt_ini = 0 behaves as 1: the channel expires one cycle after start.
- mode and cnt_ini are sampled at the moment of use (expiry or reload). Changing them mid-interval does not alter the current count.
- expired: set on expiry, cleared by clr. If set and clear coincide, set wins.
- IDLE with no start: count holds 0, busy=0, timer=0.
- Arithmetic is unsigned NBITS. The count never wraps below 0.

## Timing

- Reset values, asynchronous: state=IDLE, count=0, timer=0, busy=0, expired=0, cnt_out=0.
- start sampled at edge 0 with cnt_ini=N (N>=1) and no hold: busy=1 after edge 0; timer=1 for exactly the cycle after edge N. With hold asserted for H cycles, the pulse moves to after edge N+H.
- Auto-reload period: exactly N cycles between consecutive timer pulses, with no gap cycle.
- busy falls, in one-shot mode, after the same edge that raises timer.
- expired rises with timer and stays high until the edge after clr is sampled.
- Reset asserted mid-interval aborts immediately with no pulse. After release, the channel stays IDLE until a new start.
- cnt_out follows count combinationally on the same cycle as the rd_sel change. The count shown is the post-edge register value.

## Test plan

- Ch0, mode=0, cnt_ini=5, one-cycle start at edge 0 -> timer[0]=1 only after edge 5; busy[0] 1 for edges 0..4, 0 after edge 5; expired[0]=1 after edge 5.
- Ch1, mode=1, cnt_ini=3, start once -> timer[1] pulses after edges 3, 6, 9; busy[1] stays 1; stop at edge 10 -> busy[1]=0, count 0, no further pulses.
- Ch2, cnt_ini=4, start at edge 0, hold high for edges 2..4 -> pulse after edge 7; cnt_out with rd_sel=2 reads 3 during the hold.
- Ch3, start at edge 0 with cnt_ini=6, second start at edge 3 -> single pulse after edge 9, none after edge 6; separately, cnt_ini=0 -> pulse after edge 1.
- Reset at edge 2 of a 10-cycle interval on all channels -> all outputs 0 immediately, no pulse; clr and expiry coinciding on ch0 -> expired[0] stays 1.
